blink_gen: RTL and testbench
============================

# blink_gen

Multi-channel, parametrised LED/pulse pattern generator for the WSN SoC application layer. It is the successor of the single-channel fixed-32-bit blinker. Each channel runs its own on/off timer with separately configurable on and off phase lengths. Each channel runs either continuously or as a finite burst of N pulses with a completion pulse. An optional sync input restarts all running channels in phase.

## Interface
- `Channels`, default 4: number of independent channels (1..16).
- `CntWidth`, default 32: width of each phase timer and period value.
- `BurstWidth`, default 8: width of each burst count.
- `Clk_i` input 1: clock. Rising edge active.
- `Reset_n_i` input 1: asynchronous reset, active-low.
- `Enable_i` input `Channels`: per-channel run enable. Level sensitive.
- `OnPeriod_i` input `Channels*CntWidth`: per-channel on-phase value. Channel c uses bits `[c*CntWidth +: CntWidth]`.
- `OffPeriod_i` input `Channels*CntWidth`: per-channel off-phase value, packed the same way.
- `BurstCnt_i` input `Channels*BurstWidth`: per-channel pulse count. 0 means continuous.
- `Sync_i` input 1: phase restart strobe. Present only with `BLINK_GEN_SYNC_EN`.
- `LED_o` output `Channels`: pattern output. High exactly while the channel is in stOn.
- `Done_o` output `Channels`: one-cycle pulse when a burst completes.
- `Busy_o` output 1: OR of all channels being in stOn or stOff.

## Operation
Each channel has an FSM and the following registers:
- `State`
- `Timer[CntWidth]`
- `Remain[BurstWidth]`
- `Burst` flag (burst mode versus continuous)

FSM states:
- **stIdle**
  - `LED_o` = 0.
  - If `Enable_i[c]` = 1: load `Timer` ← On, `Remain` ← BurstCnt, `Burst` ← (BurstCnt != 0), then go to stOn.
- **stOn**
  - `LED_o` = 1.
  - If `Timer` != 0: decrement `Timer`.
  - If `Timer` = 0: load `Timer` ← Off and go to stOff.
- **stOff**
  - `LED_o` = 0.
  - If `Timer` != 0: decrement `Timer`.
  - If `Timer` = 0 and `Burst` = 1 and `Remain` = 1: go to stDone and pulse `Done_o[c]` in the cycle stDone is entered.
  - Otherwise, if `Timer` = 0: load `Timer` ← On, decrement `Remain` if `Burst` = 1, and go to stOn.
- **stDone**
  - `LED_o` = 0.
  - Hold until `Enable_i[c]` = 0, then go to stIdle. A new burst requires deasserting and reasserting enable.

Priority rules:
- `Enable_i[c]` = 0 in any state: go to stIdle on the next edge and clear `Timer`. This has priority over all other transitions.
- Sync (if compiled) has priority over timer expiry, but not over a disable.

Arithmetic and sampling rules:
- `Timer` never underflows.
- Period and burst inputs are sampled only at load time. Changes made mid-phase take effect at the next load.
- `Remain` is only decremented in burst mode. Continuous mode (BurstCnt = 0) never reaches stDone.

## Timing
Reset values: every channel in stIdle, `Timer` = 0, `Remain` = 0, `LED_o` = 0, `Done_o` = 0, `Busy_o` = 0.

Phase length and latency:
- An on phase lasts On+1 cycles. An off phase lasts Off+1 cycles. A period value of 0 gives a 1-cycle phase.
- If enable is sampled high at edge E, `LED_o` rises after edge E and falls after edge E+On+1.
- A burst of N pulses ends with `Done_o` high for the single cycle following edge E + N·(On+Off+2).
- Disable latency: `LED_o` = 0 after the first edge at which `Enable_i` is sampled low.

All outputs are driven from registers; there are no combinational paths from inputs to outputs.

Asynchronous reset mid-burst returns every channel to stIdle immediately, and no `Done_o` pulse is generated.

## Configuration
Macro: `BLINK_GEN_SYNC_EN`.

With the macro defined:
- The `Sync_i` port exists.
- `Sync_i` = 1 at an edge makes every channel in stOn or stOff reload `Timer` ← On and `Remain` ← BurstCnt, and enter stOn.
- Channels in stIdle and stDone ignore `Sync_i`.

Without the macro:
- The `Sync_i` port and its logic are absent.
- Behaviour is otherwise identical.

## Test plan
- **Reset state:** hold reset, then release → all outputs 0; channels stay idle while `Enable_i` = 0.
- **Continuous mode:** ch0 On=3, Off=1, Burst=0, enable held → `LED_o[0]` repeats 4 cycles high, 2 cycles low for ≥5 periods; `Done_o` never fires.
- **Burst mode:** ch1 On=0, Off=2, Burst=3 → exactly 3 one-cycle highs spaced 4 cycles apart. `Done_o[1]` pulses once, 12 cycles after the enable edge. The channel stays low until enable toggles.
- **Disable and reset mid-operation:**
  - Drop enable in the middle of an on phase → `LED_o` low after the next edge.
  - Re-enable → restart with a full On+1 phase.
  - Async reset mid-burst → immediate idle, no `Done_o` pulse.
- **Independence and boundary values:** run ch0..ch3 with distinct periods, including On = 2^CntWidth−1 on a CntWidth=8 build → each channel matches its own model, and `Busy_o` is the OR of all channels.
- **Sync (only with `BLINK_GEN_SYNC_EN`):** pulse `Sync_i` with channels at differing phases → all running channels rise together after that edge; idle and done channels are unaffected.

Source files
------------

// File: rtl/blink_gen.sv
// rtl/blink_gen.sv - multi-channel on/off pattern generator with continuous and burst modes
// Optional phase-restart input Sync_i is compiled in with BLINK_GEN_SYNC_EN.
module blink_gen #(
   parameter int Channels   = 4,
   parameter int CntWidth   = 32,
   parameter int BurstWidth = 8
) (
   input  logic                           Clk_i,
   input  logic                           Reset_n_i,
   input  logic [Channels-1:0]            Enable_i,
   input  logic [Channels*CntWidth-1:0]   OnPeriod_i,
   input  logic [Channels*CntWidth-1:0]   OffPeriod_i,
   input  logic [Channels*BurstWidth-1:0] BurstCnt_i,
`ifdef BLINK_GEN_SYNC_EN
   input  logic                           Sync_i,
`endif
   output logic [Channels-1:0]            LED_o,
   output logic [Channels-1:0]            Done_o,
   output logic                           Busy_o
);

   typedef enum logic [1:0] {stIdle, stOn, stOff, stDone} state_t;

   localparam logic [CntWidth-1:0]   TimerOne  = CntWidth'(1);
   localparam logic [BurstWidth-1:0] RemainOne = BurstWidth'(1);

   logic                w_sync;
   logic [Channels-1:0] w_busy;

`ifdef BLINK_GEN_SYNC_EN
   assign w_sync = Sync_i;
`else
   assign w_sync = 1'b0;
`endif

   assign Busy_o = |w_busy;

   for (genvar c = 0; c < Channels; c++) begin : g_ch
      state_t                r_state;
      state_t                w_state_nxt;
      logic [CntWidth-1:0]   r_timer;
      logic [CntWidth-1:0]   w_timer_nxt;
      logic [CntWidth-1:0]   w_on;
      logic [CntWidth-1:0]   w_off;
      logic [BurstWidth-1:0] r_remain;
      logic [BurstWidth-1:0] w_remain_nxt;
      logic [BurstWidth-1:0] w_bcnt;
      logic                  r_burst;
      logic                  w_burst_nxt;
      logic                  r_led;
      logic                  r_done;
      logic                  r_busy;

      assign w_on   = OnPeriod_i[c*CntWidth +: CntWidth];
      assign w_off  = OffPeriod_i[c*CntWidth +: CntWidth];
      assign w_bcnt = BurstCnt_i[c*BurstWidth +: BurstWidth];

      // Disable beats sync, sync beats timer expiry.
      always_comb begin
         w_state_nxt  = r_state;
         w_timer_nxt  = r_timer;
         w_remain_nxt = r_remain;
         w_burst_nxt  = r_burst;
         if (!Enable_i[c]) begin
            w_state_nxt = stIdle;
            w_timer_nxt = '0;
         end else if (w_sync && (r_state == stOn || r_state == stOff)) begin
            w_state_nxt  = stOn;
            w_timer_nxt  = w_on;
            w_remain_nxt = w_bcnt;
            w_burst_nxt  = (w_bcnt != '0);
         end else begin
            case (r_state)
               stIdle: begin
                  w_state_nxt  = stOn;
                  w_timer_nxt  = w_on;
                  w_remain_nxt = w_bcnt;
                  w_burst_nxt  = (w_bcnt != '0);
               end
               stOn: begin
                  if (r_timer != '0) begin
                     w_timer_nxt = r_timer - TimerOne;
                  end else begin
                     w_timer_nxt = w_off;
                     w_state_nxt = stOff;
                  end
               end
               stOff: begin
                  if (r_timer != '0) begin
                     w_timer_nxt = r_timer - TimerOne;
                  end else if (r_burst && r_remain == RemainOne) begin
                     w_state_nxt = stDone;
                  end else begin
                     w_timer_nxt = w_on;
                     w_state_nxt = stOn;
                     if (r_burst) begin
                        w_remain_nxt = r_remain - RemainOne;
                     end
                  end
               end
               stDone:  w_state_nxt = stDone;
               default: w_state_nxt = stIdle;
            endcase
         end
      end

      always_ff @(posedge Clk_i or negedge Reset_n_i) begin
         if (!Reset_n_i) begin
            r_state  <= stIdle;
            r_timer  <= '0;
            r_remain <= '0;
            r_burst  <= 1'b0;
            r_led    <= 1'b0;
            r_done   <= 1'b0;
            r_busy   <= 1'b0;
         end else begin
            r_state  <= w_state_nxt;
            r_timer  <= w_timer_nxt;
            r_remain <= w_remain_nxt;
            r_burst  <= w_burst_nxt;
            r_led    <= (w_state_nxt == stOn);
            r_done   <= (w_state_nxt == stDone) && (r_state != stDone);
            r_busy   <= (w_state_nxt == stOn) || (w_state_nxt == stOff);
         end
      end

      assign LED_o[c]  = r_led;
      assign Done_o[c] = r_done;
      assign w_busy[c] = r_busy;
   end

endmodule

// File: tb/tb_blink_gen.sv
// tb/tb_blink_gen.sv - directed self-checking bench for blink_gen (CntWidth=8 build)
module tb_blink_gen;

   localparam int Ch = 4;
   localparam int Cw = 8;
   localparam int Bw = 8;

   logic             Clk_i;
   logic             Reset_n_i;
   logic [Ch-1:0]    Enable_i;
   logic [Ch*Cw-1:0] OnPeriod_i;
   logic [Ch*Cw-1:0] OffPeriod_i;
   logic [Ch*Bw-1:0] BurstCnt_i;
   logic             Sync_i;
   logic [Ch-1:0]    LED_o;
   logic [Ch-1:0]    Done_o;
   logic             Busy_o;

   int checks;
   int failures;
   int cyc;

   blink_gen #(.Channels(Ch), .CntWidth(Cw), .BurstWidth(Bw)) dut (
      .Clk_i       (Clk_i),
      .Reset_n_i   (Reset_n_i),
      .Enable_i    (Enable_i),
      .OnPeriod_i  (OnPeriod_i),
      .OffPeriod_i (OffPeriod_i),
      .BurstCnt_i  (BurstCnt_i),
`ifdef BLINK_GEN_SYNC_EN
      .Sync_i      (Sync_i),
`endif
      .LED_o       (LED_o),
      .Done_o      (Done_o),
      .Busy_o      (Busy_o)
   );

   initial Clk_i = 1'b0;
   always #5 Clk_i = ~Clk_i;

   task automatic tick();
      @(posedge Clk_i);
      #1;
      cyc++;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   task automatic set_ch(input int c, input int on, input int off, input int n);
      OnPeriod_i[c*Cw +: Cw]  = Cw'(on);
      OffPeriod_i[c*Cw +: Cw] = Cw'(off);
      BurstCnt_i[c*Bw +: Bw]  = Bw'(n);
   endtask

   // k = cycles since the enabling edge (k=0 is the cycle right after it)
   function automatic logic exp_led(input int k, input int on, input int off, input int n);
      int p;
      p = on + off + 2;
      if (n != 0 && k >= n * p) return 1'b0;
      return (k % p) < (on + 1);
   endfunction

   function automatic logic exp_done(input int k, input int on, input int off, input int n);
      return (n != 0) && (k == n * (on + off + 2));
   endfunction

   function automatic logic exp_busy(input int k, input int on, input int off, input int n);
      return (n == 0) || (k < n * (on + off + 2));
   endfunction

   int e0, e1, k;
   int on_t  [Ch];
   int off_t [Ch];
   int n_t   [Ch];
   logic [Ch-1:0] xl, xd;
   logic          xb;

   initial begin
      checks = 0; failures = 0; cyc = 0;
      Reset_n_i = 1'b0; Enable_i = '0; Sync_i = 1'b0;
      OnPeriod_i = '0; OffPeriod_i = '0; BurstCnt_i = '0;

      // Reset state
      tick(); tick();
      check("rst_led", 32'(LED_o), 32'h0);
      check("rst_done", 32'(Done_o), 32'h0);
      check("rst_busy", 32'(Busy_o), 32'h0);
      Reset_n_i = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("idle_led", 32'(LED_o), 32'h0);
         check("idle_busy", 32'(Busy_o), 32'h0);
      end

      // Continuous mode: ch0 On=3 Off=1
      set_ch(0, 3, 1, 0);
      Enable_i[0] = 1'b1; e0 = cyc + 1;
      for (int i = 0; i < 32; i++) begin
         tick(); k = cyc - e0;
         check("cont_led0", 32'(LED_o[0]), 32'(exp_led(k, 3, 1, 0)));
         check("cont_done0", 32'(Done_o[0]), 32'h0);
         check("cont_busy", 32'(Busy_o), 32'h1);
      end
      // k=31 is mid on-phase; drop enable
      check("mid_on", 32'(LED_o[0]), 32'h1);
      Enable_i[0] = 1'b0;
      tick();
      check("dis_led0", 32'(LED_o[0]), 32'h0);
      check("dis_busy", 32'(Busy_o), 32'h0);
      Enable_i[0] = 1'b1; e0 = cyc + 1;
      for (int i = 0; i < 8; i++) begin
         tick(); k = cyc - e0;
         check("reen_led0", 32'(LED_o[0]), 32'(exp_led(k, 3, 1, 0)));
      end
      Enable_i[0] = 1'b0;
      tick();

      // Burst mode: ch1 On=0 Off=2 N=3 -> Done at k=12
      set_ch(1, 0, 2, 3);
      Enable_i[1] = 1'b1; e1 = cyc + 1;
      for (int i = 0; i < 20; i++) begin
         tick(); k = cyc - e1;
         check("burst_led1", 32'(LED_o[1]), 32'(exp_led(k, 0, 2, 3)));
         check("burst_done1", 32'(Done_o[1]), 32'(k == 12));
         check("burst_busy", 32'(Busy_o), 32'(k < 12));
      end
      Enable_i[1] = 1'b0;
      tick();
      check("done_idle_led", 32'(LED_o), 32'h0);
      check("done_idle_done", 32'(Done_o), 32'h0);
      Enable_i[1] = 1'b1;
      tick();
      check("burst_restart", 32'(LED_o[1]), 32'h1);

      // Async reset mid-burst
      Enable_i[1] = 1'b0;
      tick();
      Enable_i[1] = 1'b1; e1 = cyc + 1;
      for (int i = 0; i < 5; i++) begin
         tick(); k = cyc - e1;
         check("pre_rst_led1", 32'(LED_o[1]), 32'(exp_led(k, 0, 2, 3)));
      end
      Reset_n_i = 1'b0;
      #1;
      check("arst_led", 32'(LED_o), 32'h0);
      check("arst_busy", 32'(Busy_o), 32'h0);
      check("arst_done", 32'(Done_o), 32'h0);
      Enable_i = '0;
      tick(); tick();
      Reset_n_i = 1'b1;
      for (int i = 0; i < 15; i++) begin
         tick();
         check("post_rst_done", 32'(Done_o), 32'h0);
         check("post_rst_led", 32'(LED_o), 32'h0);
      end

      // Independence and boundary values (ch2 On=255 is the CntWidth=8 maximum)
      on_t = '{2, 1, 255, 0};
      off_t = '{3, 0, 0, 0};
      n_t = '{0, 2, 1, 0};
      for (int c = 0; c < Ch; c++) set_ch(c, on_t[c], off_t[c], n_t[c]);
      Enable_i = '1; e0 = cyc + 1;
      for (int i = 0; i < 264; i++) begin
         tick(); k = cyc - e0;
         xb = 1'b0;
         for (int c = 0; c < Ch; c++) begin
            xl[c] = exp_led(k, on_t[c], off_t[c], n_t[c]);
            xd[c] = exp_done(k, on_t[c], off_t[c], n_t[c]);
            xb    = xb | exp_busy(k, on_t[c], off_t[c], n_t[c]);
         end
         check("multi_led", 32'(LED_o), 32'(xl));
         check("multi_done", 32'(Done_o), 32'(xd));
         check("multi_busy", 32'(Busy_o), 32'(xb));
      end
      // Only ch2's done state must hold Busy low once others stop
      Enable_i = 4'b0100;
      tick();
      check("done_only_busy", 32'(Busy_o), 32'h0);
      check("done_only_led", 32'(LED_o), 32'h0);
      Enable_i = '0;
      tick();

`ifdef BLINK_GEN_SYNC_EN
      // Sync: ch0/ch1 running at different phases, ch2 idle, ch3 done
      on_t = '{3, 1, 0, 0};
      off_t = '{1, 2, 0, 0};
      n_t = '{0, 0, 0, 1};
      for (int c = 0; c < Ch; c++) set_ch(c, on_t[c], off_t[c], n_t[c]);
      Enable_i = 4'b1011;
      tick();
      tick(); tick(); tick(); tick();
      check("pre_sync_led", 32'(LED_o), 32'b0000);
      Sync_i = 1'b1; e0 = cyc + 1;
      tick();
      Sync_i = 1'b0;
      check("sync_rise", 32'(LED_o), 32'b0011);
      check("sync_done", 32'(Done_o), 32'h0);
      for (int i = 0; i < 10; i++) begin
         tick(); k = cyc - e0;
         check("sync_led0", 32'(LED_o[0]), 32'(exp_led(k, 3, 1, 0)));
         check("sync_led1", 32'(LED_o[1]), 32'(exp_led(k, 1, 2, 0)));
         check("sync_idle_done", 32'(LED_o[3:2]), 32'h0);
         check("sync_nodone", 32'(Done_o), 32'h0);
      end
      Enable_i = '0;
      tick();
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
